// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM states, protocol bytes and arrow scan codes
// (the arrow codes are also consumed by the sprite-motion FSM).
package ps2_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_PAUSE = 8'hE1;

  localparam logic [BYTE_W-1:0] KEY_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] KEY_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] KEY_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] KEY_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning.
//   clk, rst_n       : system clock, async active-low reset
//   clk_pin          : raw ps2_clk, 2-flop synchronized then glitch-filtered
//   data_pin         : raw ps2_data, 2-flop synchronized only
//   data_sync_o      : synchronized ps2_data
//   clk_fall_o       : 1-cycle pulse on a filtered ps2_clk 1->0 transition
module ps2_line_sync #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic data_pin,
  output logic data_sync_o,
  output logic clk_fall_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             clk_meta_q, clk_meta_d;
  logic             clk_sync_q, clk_sync_d;
  logic             data_meta_q, data_meta_d;
  logic             data_sync_q, data_sync_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Filtered level follows the synced level only after FILTER_LEN consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    clk_meta_d  = clk_pin;
    clk_sync_d  = clk_meta_q;
    data_meta_d = data_pin;
    data_sync_d = data_meta_q;
    filt_d      = filt_q;
    cnt_d       = '0;
    fall_d      = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
        fall_d = ~clk_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Lines idle high, so all stages reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign data_sync_o = data_sync_q;
  assign clk_fall_o  = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and make/break/extended decoder.
//   clk, rst_n   : system clock, async active-low reset
//   ps2_clk/data : raw asynchronous PS/2 pins
//   keycode      : base scan code of the held key, 0 when none
//   extended     : held key was E0-prefixed
//   key_valid    : pulse per accepted make code (repeats included)
//   key_release  : pulse per accepted break code
//   frame_err    : pulse on start/parity/stop/timeout error
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] keycode,
  output logic              extended,
  output logic              key_valid,
  output logic              key_release,
  output logic              frame_err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

  logic data_sync, clk_fall;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_pin    (ps2_clk),
    .data_pin   (ps2_data),
    .data_sync_o(data_sync),
    .clk_fall_o (clk_fall)
  );

  ps2_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 ext_pend_q, ext_pend_d;
  logic                 brk_pend_q, brk_pend_d;
  logic [BYTE_W-1:0]    keycode_q, keycode_d;
  logic                 extended_q, extended_d;
  logic                 key_valid_q, key_valid_d;
  logic                 key_release_q, key_release_d;
  logic                 frame_err_q, frame_err_d;

  // Frame FSM, byte interpretation and held-key tracking.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    keycode_d     = keycode_q;
    extended_d    = extended_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    frame_err_d   = 1'b0;

    // Saturating idle-line counter, held at zero in IDLE and on every fall.
    if (state_q == IDLE || clk_fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (state_q != IDLE && !clk_fall && tmo_q == TMO_MAX) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end else if (clk_fall) begin
      case (state_q)
        IDLE: begin
          if (!data_sync) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d   = {data_sync, shreg_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_sync;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shreg_q, par_q}) && data_sync) begin
            case (shreg_q)
              PS2_EXT: ext_pend_d = 1'b1;
              PS2_BRK: brk_pend_d = 1'b1;
              PS2_PAUSE: begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
              end
              default: begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (!brk_pend_q) begin
                  keycode_d   = shreg_q;
                  extended_d  = ext_pend_q;
                  key_valid_d = 1'b1;
                end else begin
                  key_release_d = 1'b1;
                  // Releasing a key other than the held one leaves it held.
                  if ({ext_pend_q, shreg_q} == {extended_q, keycode_q}) begin
                    keycode_d  = '0;
                    extended_d = 1'b0;
                  end
                end
              end
            endcase
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      keycode_q     <= '0;
      extended_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      keycode_q     <= keycode_d;
      extended_q    <= extended_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign keycode     = keycode_q;
  assign extended    = extended_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign frame_err   = frame_err_q;

endmodule
